// File: rtl/tusca_uc_pkg.sv
// Shared definitions for the TUSCA control unit: state codes (also used by the
// top-level debug/hex display) and small arithmetic helpers.
package tusca_uc_pkg;

  typedef enum logic [3:0] {
    ST_INICIAL            = 4'd0,
    ST_CONFIG             = 4'd1,
    ST_ESPERA_CONFIG      = 4'd2,
    ST_MEDE               = 4'd3,
    ST_ESPERA_MEDIDA      = 4'd4,
    ST_TRANSMITE          = 4'd5,
    ST_ESPERA_TRANSMISSAO = 4'd6,
    ST_INTERVALO          = 4'd7,
    ST_ERRO               = 4'd8
  } estado_e;

  localparam logic [3:0] ERROS_SAT = 4'd15;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [3:0] inc_sat(input logic [3:0] v);
    return (v == ERROS_SAT) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/tusca_uc_detector_borda.sv
// Rising-edge detector for an asynchronous level: two-flop synchroniser, then a
// registered one-cycle pulse on each 0->1 transition.
module detector_borda (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sinal_i,
  output logic borda_o
);

  logic [2:0] sync_q;
  logic       borda_q;

  // sync_q[1] is the synchronised level, sync_q[2] its previous value
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 3'b000;
      borda_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], sinal_i};
      borda_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign borda_o = borda_q;

endmodule

// File: rtl/tusca_uc.sv
// TUSCA control unit: sequences config, DHT11 measurement, transmission and the
// measurement interval; counts consecutive failures and raises the alarm.
module tusca_uc
  import tusca_uc_pkg::*;
#(
  parameter int INTERVALO_MS = 3000,
  parameter int TIMEOUT_MS   = 2000,
  parameter int MAX_ERROS    = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       pedir_config,
  input  logic       fim_delay,
  input  logic       pronto_config,
  input  logic       erro_config,
  input  logic       pronto_medida,
  input  logic       erro_medida,
  input  logic       pronto_transmite_medida,
  output logic       zera_delay,
  output logic       conta_delay,
  output logic       receber_config,
  output logic       medir_dht11,
  output logic       transmite_medida,
  output logic       gira,
  output logic       alarme,
  output logic [3:0] db_estado,
  output logic [3:0] db_erros
);

  localparam int              CNT_MAX = max_int(INTERVALO_MS, TIMEOUT_MS);
  localparam int              CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0]   CNT_LIM = CW'(CNT_MAX);
  localparam logic [CW-1:0]   INT_LIM = CW'(INTERVALO_MS);
  localparam logic [CW-1:0]   TMO_LIM = CW'(TIMEOUT_MS);
  localparam logic [3:0]      MAX_LIM = 4'(MAX_ERROS);

  estado_e       estado_q, estado_d;
  logic [CW-1:0] ms_cnt_q, ms_cnt_d;
  logic [3:0]    erros_q, erros_d;
  logic          config_pendente_q, config_pendente_d;
  logic          zera_q, conta_q, receber_q, medir_q, transmite_q, gira_q, alarme_q;
  logic          zera_d, conta_d, receber_d, medir_d, transmite_d, gira_d, alarme_d;
  logic          borda_s, timeout_s, intervalo_fim_s;

  detector_borda u_borda (
    .clk_i   (clock),
    .rst_ni  (reset),
    .sinal_i (pedir_config),
    .borda_o (borda_s)
  );

  // zera_q also marks the first INTERVALO cycle, where a stale count must not end the interval
  assign timeout_s       = (ms_cnt_q == TMO_LIM);
  assign intervalo_fim_s = !zera_q && (ms_cnt_q == INT_LIM);

  // Next-state, failure counter and pending-config decisions
  always_comb begin
    estado_d = estado_q;
    erros_d  = erros_q;
    case (estado_q)
      ST_INICIAL: begin
        if (ligar) estado_d = config_pendente_q ? ST_CONFIG : ST_MEDE;
        else       estado_d = ST_INICIAL;
      end
      ST_CONFIG:    estado_d = ST_ESPERA_CONFIG;
      ST_MEDE:      estado_d = ST_ESPERA_MEDIDA;
      ST_TRANSMITE: estado_d = ST_ESPERA_TRANSMISSAO;
      ST_ESPERA_CONFIG: begin
        if (pronto_config || erro_config || timeout_s) estado_d = ST_MEDE;
        else                                           estado_d = ST_ESPERA_CONFIG;
      end
      ST_ESPERA_MEDIDA: begin
        if (erro_medida || timeout_s) begin
          erros_d  = inc_sat(erros_q);
          estado_d = (erros_d == MAX_LIM) ? ST_ERRO : ST_INTERVALO;
        end else if (pronto_medida) begin
          erros_d  = 4'd0;
          estado_d = ST_TRANSMITE;
        end else begin
          estado_d = ST_ESPERA_MEDIDA;
        end
      end
      ST_ESPERA_TRANSMISSAO: begin
        if (pronto_transmite_medida || timeout_s) estado_d = ST_INTERVALO;
        else                                      estado_d = ST_ESPERA_TRANSMISSAO;
      end
      ST_INTERVALO: begin
        if (!ligar)                 estado_d = ST_INICIAL;
        else if (config_pendente_q) estado_d = ST_CONFIG;
        else if (intervalo_fim_s)   estado_d = ST_MEDE;
        else                        estado_d = ST_INTERVALO;
      end
      ST_ERRO: begin
        if (!ligar) begin
          estado_d = ST_INICIAL;
          erros_d  = 4'd0;
        end else begin
          estado_d = ST_ERRO;
        end
      end
      default: estado_d = ST_INICIAL;
    endcase

    if (borda_s)                     config_pendente_d = 1'b1;
    else if (estado_d == ST_CONFIG)  config_pendente_d = 1'b0;
    else                             config_pendente_d = config_pendente_q;

    if (zera_q)                                          ms_cnt_d = '0;
    else if (conta_q && fim_delay && ms_cnt_q != CNT_LIM) ms_cnt_d = ms_cnt_q + CW'(1);
    else                                                  ms_cnt_d = ms_cnt_q;
  end

  // Moore outputs computed from the next state so they register alongside it
  always_comb begin
    zera_d      = 1'b0;
    conta_d     = 1'b0;
    receber_d   = 1'b0;
    medir_d     = 1'b0;
    transmite_d = 1'b0;
    gira_d      = 1'b0;
    alarme_d    = 1'b0;
    case (estado_d)
      ST_CONFIG:    begin receber_d   = 1'b1; zera_d = 1'b1; end
      ST_MEDE:      begin medir_d     = 1'b1; zera_d = 1'b1; end
      ST_TRANSMITE: begin transmite_d = 1'b1; zera_d = 1'b1; end
      ST_ESPERA_CONFIG, ST_ESPERA_MEDIDA, ST_ESPERA_TRANSMISSAO: conta_d = 1'b1;
      ST_INTERVALO: begin
        gira_d = 1'b1;
        if (estado_q == ST_INTERVALO) conta_d = 1'b1;
        else                          zera_d  = 1'b1;
      end
      ST_ERRO:      alarme_d = 1'b1;
      default:      zera_d   = 1'b0;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q          <= ST_INICIAL;
      ms_cnt_q          <= '0;
      erros_q           <= 4'd0;
      config_pendente_q <= 1'b1;
      zera_q            <= 1'b0;
      conta_q           <= 1'b0;
      receber_q         <= 1'b0;
      medir_q           <= 1'b0;
      transmite_q       <= 1'b0;
      gira_q            <= 1'b0;
      alarme_q          <= 1'b0;
    end else begin
      estado_q          <= estado_d;
      ms_cnt_q          <= ms_cnt_d;
      erros_q           <= erros_d;
      config_pendente_q <= config_pendente_d;
      zera_q            <= zera_d;
      conta_q           <= conta_d;
      receber_q         <= receber_d;
      medir_q           <= medir_d;
      transmite_q       <= transmite_d;
      gira_q            <= gira_d;
      alarme_q          <= alarme_d;
    end
  end

  assign zera_delay       = zera_q;
  assign conta_delay      = conta_q;
  assign receber_config   = receber_q;
  assign medir_dht11      = medir_q;
  assign transmite_medida = transmite_q;
  assign gira             = gira_q;
  assign alarme           = alarme_q;
  assign db_estado        = estado_q;
  assign db_erros         = erros_q;

endmodule
